// File: rtl/neuron_writeback.sv
// Neuron write-back stage: counts MAC steps, rescales/saturates the final
// accumulator and writes it to neuron RAM. Optional macro NEURON_RELU_EN selects ReLU.
module neuron_writeback #(
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 16,
    parameter int ADDR_W     = 8,
    parameter int FRAC_SHIFT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [7:0]              nk,
    input  logic [7:0]              num_neurons,
    input  logic [ADDR_W-1:0]       write_base,
    input  logic                    acc_valid,
    input  logic signed [ACC_W-1:0] acc_in,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [DATA_W-1:0]       wr_data,
    output logic                    mac_forget,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [2:0]              dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACCUM = 3'd1,
        S_ACT   = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [DATA_W-1:0]       OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]       OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    state_t state;
    state_t state_next;

    logic [7:0]              nk_q;
    logic [7:0]              num_neurons_q;
    logic [ADDR_W-1:0]       write_base_q;
    logic [7:0]              in_cnt;
    logic [7:0]              neuron_idx;
    logic signed [ACC_W-1:0] acc_reg;
    logic signed [ACC_W-1:0] shifted;
    logic [DATA_W-1:0]       sat_val;

    logic take_start;
    logic bad_cfg;
    logic acc_step;
    logic acc_last;
    logic act_load;
    logic next_neuron;
    logic overrun;

    assign bad_cfg   = (nk == 8'd0) || (num_neurons == 8'd0);
    assign dbg_state = state;

    // acc_valid has no ready: a value is consumed only in ACCUM (or ignored on
    // the accepted start cycle); in any other state it is dropped and flagged in err.
    assign overrun = acc_valid && (state != S_ACCUM) && !(state == S_IDLE && start);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        take_start  = 1'b0;
        acc_step    = 1'b0;
        acc_last    = 1'b0;
        act_load    = 1'b0;
        next_neuron = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        mac_forget  = 1'b0;
        done        = 1'b0;
        busy        = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start) begin
                    take_start = 1'b1;
                    state_next = bad_cfg ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (acc_valid) begin
                    acc_step = 1'b1;
                    if (in_cnt == nk_q - 8'd1) begin
                        acc_last   = 1'b1;
                        state_next = S_ACT;
                    end
                end
            end
            S_ACT: begin
                act_load   = 1'b1;
                state_next = S_WRITE;
            end
            S_WRITE: begin
                wr_en      = 1'b1;
                mac_forget = 1'b1;
                // Address wraps modulo 2^ADDR_W by construction.
                wr_addr    = write_base_q + ADDR_W'(neuron_idx);
                if (neuron_idx == num_neurons_q - 8'd1) begin
                    state_next = S_DONE;
                end else begin
                    next_neuron = 1'b1;
                    state_next  = S_ACCUM;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign shifted = acc_reg >>> FRAC_SHIFT;

`ifdef NEURON_RELU_EN
    always_comb begin
        if (shifted[ACC_W-1]) begin
            sat_val = '0;
        end else if (shifted > SAT_MAX) begin
            sat_val = OUT_MAX;
        end else begin
            sat_val = shifted[DATA_W-1:0];
        end
    end
`else
    always_comb begin
        if (shifted > SAT_MAX) begin
            sat_val = OUT_MAX;
        end else if (shifted < SAT_MIN) begin
            sat_val = OUT_MIN;
        end else begin
            sat_val = shifted[DATA_W-1:0];
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nk_q          <= '0;
            num_neurons_q <= '0;
            write_base_q  <= '0;
        end else if (take_start) begin
            nk_q          <= nk;
            num_neurons_q <= num_neurons;
            write_base_q  <= write_base;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_cnt     <= '0;
            neuron_idx <= '0;
        end else if (take_start) begin
            in_cnt     <= '0;
            neuron_idx <= '0;
        end else if (next_neuron) begin
            in_cnt     <= '0;
            neuron_idx <= neuron_idx + 8'd1;
        end else if (acc_step) begin
            in_cnt <= in_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_reg <= '0;
        end else if (acc_last) begin
            acc_reg <= acc_in;
        end
    end

    // wr_data is only reloaded in ACT so it holds its value everywhere else.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_data <= '0;
        end else if (act_load) begin
            wr_data <= sat_val;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (take_start) begin
            err <= bad_cfg;
        end else if (overrun) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_neuron_writeback.sv
// Directed testbench for neuron_writeback; expected writes are hand-computed
// and held in a scoreboard queue of {addr, data}.
module tb_neuron_writeback;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  nk;
    logic [7:0]  num_neurons;
    logic [7:0]  write_base;
    logic        acc_valid;
    logic [15:0] acc_in;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        mac_forget;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    int forget_cnt = 0;
    int done_cnt   = 0;
    int f0;
    int d0;
    logic [15:0] exp_q[$];

    neuron_writeback dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .nk         (nk),
        .num_neurons(num_neurons),
        .write_base (write_base),
        .acc_valid  (acc_valid),
        .acc_in     (acc_in),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .mac_forget (mac_forget),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every write is matched against the head of exp_q.
    always @(negedge clk) begin
        if (mac_forget) forget_cnt++;
        if (done) done_cnt++;
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                check("wr_spurious", {31'b0, wr_en}, 32'd0);
            end else begin
                check("wr_addr_data", {16'b0, wr_addr, wr_data}, {16'b0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] n, input logic [7:0] nn, input logic [7:0] base);
        start       = 1'b1;
        nk          = n;
        num_neurons = nn;
        write_base  = base;
        tick();
        start = 1'b0;
    endtask

    task automatic send_acc(input logic [15:0] v);
        acc_valid = 1'b1;
        acc_in    = v;
        tick();
        acc_valid = 1'b0;
    endtask

    // Sends n values (fillers then `last`) and steps through ACT and WRITE.
    task automatic run_neuron(input int n, input logic [15:0] last);
        for (int i = 0; i < n - 1; i++) send_acc(16'h0040 + 16'(i));
        send_acc(last);
        tick();
        tick();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check(tag, {31'b0, busy}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {24'b0, wr_en, mac_forget, busy, done, err, 3'b0},  32'd0);
        check({tag, "_bus"}, {16'b0, wr_addr, wr_data}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; nk = '0; num_neurons = '0;
        write_base = '0; acc_valid = 1'b0; acc_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_outs");
        reset = 1'b1;
        tick();

        // Basic write: 0x0230 >>> 4 = 0x23 at address 10.
        exp_q.push_back({8'd10, 8'h23});
        do_start(8'd3, 8'd1, 8'd10);
        send_acc(16'h0100);
        send_acc(16'h0020);
        send_acc(16'h0230);
        check("lat_act", {30'b0, wr_en, busy}, 32'b01);
        tick();
        check("lat_write", {29'b0, wr_en, mac_forget, done}, 32'b110);
        check("lat_addr", {24'b0, wr_addr}, 32'd10);
        check("lat_data", {24'b0, wr_data}, 32'h23);
        tick();
        check("lat_done", {30'b0, done, wr_en}, 32'b10);
        check("hold_data", {16'b0, wr_addr, wr_data}, {16'b0, 8'h00, 8'h23});
        tick();
        check("lat_idle", {30'b0, done, busy}, 32'b00);

        // Saturation / activation, one input per neuron.
`ifdef NEURON_RELU_EN
        exp_q.push_back({8'h20, 8'h7F});
        exp_q.push_back({8'h21, 8'h00});
        exp_q.push_back({8'h22, 8'h00});
        exp_q.push_back({8'h23, 8'h7F});
        exp_q.push_back({8'h24, 8'h7F});
        exp_q.push_back({8'h25, 8'h00});
        exp_q.push_back({8'h26, 8'h00});
`else
        exp_q.push_back({8'h20, 8'h7F});
        exp_q.push_back({8'h21, 8'hF0});
        exp_q.push_back({8'h22, 8'h80});
        exp_q.push_back({8'h23, 8'h7F});
        exp_q.push_back({8'h24, 8'h7F});
        exp_q.push_back({8'h25, 8'h80});
        exp_q.push_back({8'h26, 8'h80});
`endif
        do_start(8'd1, 8'd7, 8'h20);
        run_neuron(1, 16'h7FF0);
        run_neuron(1, 16'hFF00);
        run_neuron(1, 16'h8000);
        run_neuron(1, 16'h07F0);
        run_neuron(1, 16'h0800);
        run_neuron(1, 16'hF7F0);
        run_neuron(1, 16'hF800);
        wait_idle("sat_idle");
        check("sat_drained", exp_q.size(), 32'd0);

        // Multi-neuron with address wrap.
        exp_q.push_back({8'hFE, 8'h10});
        exp_q.push_back({8'hFF, 8'h05});
        exp_q.push_back({8'h00, 8'h70});
        f0 = forget_cnt;
        d0 = done_cnt;
        do_start(8'd2, 8'd3, 8'hFE);
        run_neuron(2, 16'h0100);
        run_neuron(2, 16'h0050);
        run_neuron(2, 16'h0700);
        wait_idle("wrap_idle");
        check("wrap_drained", exp_q.size(), 32'd0);
        check("wrap_forgets", forget_cnt - f0, 32'd3);
        check("wrap_dones", done_cnt - d0, 32'd1);

        // Degenerate starts.
        do_start(8'd0, 8'd2, 8'd5);
        check("nk0_done", {28'b0, done, err, busy, wr_en}, 32'b1110);
        tick();
        check("nk0_after", {29'b0, done, busy, err}, 32'b001);
        do_start(8'd3, 8'd0, 8'd5);
        check("nn0_done", {29'b0, done, err, wr_en}, 32'b110);
        tick();

        // New start clears err; overrun during ACT keeps the captured value.
        exp_q.push_back({8'h40, 8'h23});
        do_start(8'd2, 8'd1, 8'h40);
        check("err_cleared", {31'b0, err}, 32'd0);
        send_acc(16'h0100);
        send_acc(16'h0230);
        send_acc(16'h7FF0);
        check("ovr_write", {29'b0, err, wr_en, mac_forget}, 32'b111);
        check("ovr_data", {24'b0, wr_data}, 32'h23);
        wait_idle("ovr_idle");
        check("err_sticky", {31'b0, err}, 32'd1);

        // Reset mid-ACCUM aborts at once.
        f0 = forget_cnt;
        d0 = done_cnt;
        do_start(8'd4, 8'd1, 8'h50);
        send_acc(16'h0100);
        send_acc(16'h0200);
        #3;
        reset = 1'b0;
        #1;
        check_all_zero("rst_mid");
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check("rst_no_pulses", (forget_cnt - f0) + (done_cnt - d0), 32'd0);
        exp_q.push_back({8'h60, 8'h12});
        do_start(8'd1, 8'd1, 8'h60);
        run_neuron(1, 16'h0120);
        wait_idle("rst_recover_idle");
        check("rst_recover_drained", exp_q.size(), 32'd0);

        // start while busy is ignored; nk stays 2 and base stays 0x70.
        exp_q.push_back({8'h70, 8'h34});
        do_start(8'd2, 8'd1, 8'h70);
        send_acc(16'h0010);
        do_start(8'd5, 8'd3, 8'h99);
        send_acc(16'h0340);
        check("busy_act", {30'b0, busy, wr_en}, 32'b10);
        tick();
        check("busy_write", {23'b0, wr_en, wr_addr}, {23'b0, 1'b1, 8'h70});
        wait_idle("busy_idle");

        tick();
        check("final_queue", exp_q.size(), 32'd0);
        check("final_forgets", forget_cnt, 32'd14);
        check("final_dones", done_cnt, 32'd8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
